// File: rtl/mem_stage_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : mem_stage_pkg                                                |
// | Purpose : Shared types and widths for the MIPS32 MEM pipeline stage.   |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package mem_stage_pkg;

  localparam int WORD_W = 32;  // data word width
  localparam int CNT_W  = 4;   // wait-state counter width (0..15 wait cycles)

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_dmem_array.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : dmem_array                                                   |
// | Purpose : DEPTH x 32 word-addressed data memory, one synchronous write |
// |           port and one asynchronous read port. Contents are not reset. |
// | Ports   : clk      - write clock (rising edge)                         |
// |           i_we     - write enable                                      |
// |           i_waddr  - write word index                                  |
// |           i_wdata  - write data                                        |
// |           i_raddr  - read word index                                   |
// |           o_rdata  - read data (combinational)                         |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module dmem_array
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WORD_W-1:0] o_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : mem_access_stage                                             |
// | Purpose : MEM stage of the 5-stage MIPS32 pipeline. Executes lw/sw on  |
// |           an internal data memory with WAIT_CYCLES wait states, stalls |
// |           the front of the pipe while an access is outstanding and     |
// |           drives the MEM/WB register inputs combinationally.           |
// | Ports   : clk, reset (async, active-high)                              |
// |           MemRead_in/MemWrite_in  - load/store request                 |
// |           MemtoReg_in/RegWrite_in - WB controls (bubbled on stall)     |
// |           alu_out_in              - byte address or ALU result         |
// |           write_data_in           - store data                         |
// |           rd_in                   - destination register               |
// |           MemtoReg_out/RegWrite_out/data_out/alu_out_out/rd_out -> WB  |
// |           stall_out               - freezes upstream stages            |
// |           misalign_err            - misaligned access this cycle       |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_in,
  input  logic              MemWrite_in,
  input  logic              MemtoReg_in,
  input  logic              RegWrite_in,
  input  logic [WORD_W-1:0] alu_out_in,
  input  logic [WORD_W-1:0] write_data_in,
  input  logic [4:0]        rd_in,
  output logic              MemtoReg_out,
  output logic              RegWrite_out,
  output logic [WORD_W-1:0] data_out,
  output logic [WORD_W-1:0] alu_out_out,
  output logic [4:0]        rd_out,
  output logic              stall_out,
  output logic              misalign_err
);

  localparam bit C_NO_WAIT = (WAIT_CYCLES == 0);
  localparam logic [CNT_W-1:0] C_CNT_INIT =
      (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;

  logic              w_req;
  logic              w_aligned;
  logic              w_access;
  logic              w_stall;
  logic              w_done;
  logic              w_we;
  logic              w_is_load;
  logic [ADDR_W-1:0] w_idx;
  logic [WORD_W-1:0] w_rdata;

  assign w_req     = MemRead_in | MemWrite_in;
  assign w_aligned = (alu_out_in[1:0] == 2'b00);
  assign w_access  = w_req & w_aligned;
  // A request with both read and write set behaves as a store only.
  assign w_is_load = MemRead_in & ~MemWrite_in;
  // Upper address bits are dropped so accesses wrap modulo DEPTH.
  assign w_idx     = alu_out_in[ADDR_W+1:2];

  // ---------------- FSM: state and counter registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------- FSM: next state and stall/done decode -----------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_access) begin
          if (C_NO_WAIT) begin
            w_done = 1'b1;
          end else begin
            w_stall     = 1'b1;
            w_cnt_nxt   = C_CNT_INIT;
            w_state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt != '0) begin
          w_stall   = 1'b1;
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          // Final cycle: upstream has held the request stable, so the
          // same inputs complete the access now.
          w_done      = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Reset gates the write so a store interrupted mid-WAIT is never committed.
  assign w_we = w_done & MemWrite_in & ~reset;

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_dmem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_idx),
    .i_wdata (write_data_in),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  // ---------------- Outputs toward MEM/WB ----------------
  assign stall_out    = ~reset & w_stall;
  assign RegWrite_out = ~reset & ~w_stall & RegWrite_in;
  assign MemtoReg_out = ~reset & ~w_stall & MemtoReg_in;
  assign data_out     = (~reset & w_done & w_is_load) ? w_rdata : '0;
  assign misalign_err = ~reset & w_req & ~w_aligned;
  assign alu_out_out  = alu_out_in;
  assign rd_out       = rd_in;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_mem_access_stage                                          |
// | Purpose : Scoreboard bench for mem_access_stage with three instances   |
// |           (0, 2 and 3 wait states) sharing clock, reset and data.      |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_mem_access_stage;

  typedef struct packed {
    logic [31:0] data;
    logic        rw;
    logic        m2r;
    logic        mis;
    logic [4:0]  rd;
    logic [31:0] alu;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        rw_in;
  logic        m2r_in;
  logic [31:0] alu_in;
  logic [31:0] wd_in;
  logic [4:0]  rd_in;
  logic        mr    [3];
  logic        mw    [3];

  logic        m2ro  [3];
  logic        rwo   [3];
  logic [31:0] dout  [3];
  logic [31:0] aluo  [3];
  logic [4:0]  rdo   [3];
  logic        stall [3];
  logic        mis   [3];

  int   checks;
  int   errors;
  int   sel;
  logic active;
  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(8), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .MemRead_in(mr[0]), .MemWrite_in(mw[0]),
    .MemtoReg_in(m2r_in), .RegWrite_in(rw_in), .alu_out_in(alu_in),
    .write_data_in(wd_in), .rd_in(rd_in), .MemtoReg_out(m2ro[0]),
    .RegWrite_out(rwo[0]), .data_out(dout[0]), .alu_out_out(aluo[0]),
    .rd_out(rdo[0]), .stall_out(stall[0]), .misalign_err(mis[0]));

  mem_access_stage #(.ADDR_W(8), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .MemRead_in(mr[1]), .MemWrite_in(mw[1]),
    .MemtoReg_in(m2r_in), .RegWrite_in(rw_in), .alu_out_in(alu_in),
    .write_data_in(wd_in), .rd_in(rd_in), .MemtoReg_out(m2ro[1]),
    .RegWrite_out(rwo[1]), .data_out(dout[1]), .alu_out_out(aluo[1]),
    .rd_out(rdo[1]), .stall_out(stall[1]), .misalign_err(mis[1]));

  mem_access_stage #(.ADDR_W(8), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .reset(reset), .MemRead_in(mr[2]), .MemWrite_in(mw[2]),
    .MemtoReg_in(m2r_in), .RegWrite_in(rw_in), .alu_out_in(alu_in),
    .write_data_in(wd_in), .rd_in(rd_in), .MemtoReg_out(m2ro[2]),
    .RegWrite_out(rwo[2]), .data_out(dout[2]), .alu_out_out(aluo[2]),
    .rd_out(rdo[2]), .stall_out(stall[2]), .misalign_err(mis[2]));

  // Monitor: whenever the selected instance presents a non-stalled result
  // for an issued operation, pop the expectation and compare.
  always @(negedge clk) begin
    exp_t e;
    if (active && !stall[sel]) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL result: unexpected output, scoreboard empty");
      end else begin
        e = exp_q.pop_front();
        if (dout[sel] !== e.data || rwo[sel] !== e.rw || m2ro[sel] !== e.m2r ||
            mis[sel] !== e.mis || rdo[sel] !== e.rd || aluo[sel] !== e.alu) begin
          errors++;
          $display("FAIL result dut%0d: got data=%h rw=%b m2r=%b mis=%b rd=%0d alu=%h exp data=%h rw=%b m2r=%b mis=%b rd=%0d alu=%h",
                   sel, dout[sel], rwo[sel], m2ro[sel], mis[sel], rdo[sel], aluo[sel],
                   e.data, e.rw, e.m2r, e.mis, e.rd, e.alu);
        end
      end
      active = 1'b0;
    end
  end

  // Issue one operation at posedge+1, count its stall cycles, and return
  // at posedge+1 of the cycle after completion with requests dropped.
  task automatic do_op(input int d, input logic r, input logic w,
                       input logic rw, input logic m2r,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [31:0] ed,
                       input logic erw, input logic em2r, input logic emis,
                       input int estall);
    exp_t e;
    int   n;
    bit   done;
    sel    = d;
    mr[d]  = r;
    mw[d]  = w;
    rw_in  = rw;
    m2r_in = m2r;
    alu_in = a;
    wd_in  = wd;
    rd_in  = rd;
    e.data = ed; e.rw = erw; e.m2r = em2r; e.mis = emis; e.rd = rd; e.alu = a;
    exp_q.push_back(e);
    active = 1'b1;
    n    = 0;
    done = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (stall[d]) begin
        n++;
        checks++;
        if (rwo[d] !== 1'b0 || m2ro[d] !== 1'b0 || dout[d] !== 32'h0) begin
          errors++;
          $display("FAIL bubble dut%0d: rw=%b m2r=%b data=%h exp 0/0/0",
                   d, rwo[d], m2ro[d], dout[d]);
        end
        @(posedge clk);
      end else begin
        done = 1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL timeout dut%0d: stall never dropped", d);
      active = 1'b0;
      void'(exp_q.pop_back());
    end else if (n != estall) begin
      errors++;
      $display("FAIL stall_count dut%0d addr=%h: got %0d exp %0d", d, a, n, estall);
    end
    @(posedge clk);
    #1;
    mr[d] = 1'b0;
    mw[d] = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exv);
    checks++;
    if (act !== exv) begin
      errors++;
      $display("FAIL %s: got %h exp %h", nm, act, exv);
    end
  endtask

  initial begin
    checks = 0; errors = 0; sel = 0; active = 1'b0;
    for (int i = 0; i < 3; i++) begin mr[i] = 1'b0; mw[i] = 1'b0; end
    reset = 1'b1; rw_in = 1'b1; m2r_in = 1'b1; alu_in = 32'h0000_A5A4;
    wd_in = 32'h0; rd_in = 5'd3;
    mr[2] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    // Reset state: controls forced low, address/rd pass through.
    for (int i = 0; i < 3; i++) begin
      chk("reset_ctrl", {29'h0, stall[i], rwo[i], m2ro[i]}, 32'h0);
      chk("reset_data", dout[i], 32'h0);
      chk("reset_mis", {31'h0, mis[i]}, 32'h0);
      chk("reset_alu_pass", aluo[i], 32'h0000_A5A4);
      chk("reset_rd_pass", {27'h0, rdo[i]}, 32'd3);
    end
    @(posedge clk); #1;
    reset = 1'b0; mr[2] = 1'b0;

    // Test 1 (N=0): store then load on the next cycle.
    do_op(0, 0, 1, 0, 0, 32'h20, 32'hCAFEF00D, 5'd0, 32'h0, 0, 0, 0, 0);
    do_op(0, 1, 0, 1, 1, 32'h20, 32'h0, 5'd5, 32'hCAFEF00D, 1, 1, 0, 0);

    // Test 2 (N=3): preload then load with three stall cycles.
    do_op(2, 0, 1, 0, 0, 32'h08, 32'h11223344, 5'd0, 32'h0, 0, 0, 0, 3);
    do_op(2, 1, 0, 1, 1, 32'h08, 32'h0, 5'd9, 32'h11223344, 1, 1, 0, 3);

    // Test 3 (N=2): preload two words then back-to-back loads.
    do_op(1, 0, 1, 0, 0, 32'h30, 32'hAAAA0001, 5'd0, 32'h0, 0, 0, 0, 2);
    do_op(1, 0, 1, 0, 0, 32'h34, 32'hBBBB0002, 5'd0, 32'h0, 0, 0, 0, 2);
    do_op(1, 1, 0, 1, 1, 32'h30, 32'h0, 5'd10, 32'hAAAA0001, 1, 1, 0, 2);
    do_op(1, 1, 0, 1, 1, 32'h34, 32'h0, 5'd11, 32'hBBBB0002, 1, 1, 0, 2);
    // Both requests set: treated as a store, no load data returned.
    do_op(1, 1, 1, 1, 1, 32'h38, 32'h5EED5EED, 5'd12, 32'h0, 1, 1, 0, 2);
    do_op(1, 1, 0, 1, 1, 32'h38, 32'h0, 5'd13, 32'h5EED5EED, 1, 1, 0, 2);

    // Test 4 (N=3): store aborted by reset in its second stall cycle.
    do_op(2, 0, 1, 0, 0, 32'h10, 32'h0, 5'd0, 32'h0, 0, 0, 0, 3);
    sel = 2; mw[2] = 1'b1; alu_in = 32'h10; wd_in = 32'hDEADBEEF;
    rw_in = 1'b0; m2r_in = 1'b0;
    @(negedge clk);
    chk("abort_stall_first", {31'h0, stall[2]}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_stall_in_reset", {31'h0, stall[2]}, 32'h0);
    chk("abort_outs_in_reset", {dout[2][30:0], rwo[2]}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0; mw[2] = 1'b0;
    @(negedge clk);
    chk("abort_idle_after", {31'h0, stall[2]}, 32'h0);
    @(posedge clk); #1;
    do_op(2, 1, 0, 1, 1, 32'h10, 32'h0, 5'd4, 32'h0, 1, 1, 0, 3);

    // Test 5: misaligned store leaves memory alone; address wraps.
    do_op(0, 0, 1, 0, 0, 32'h20, 32'h55AA55AA, 5'd0, 32'h0, 0, 0, 0, 0);
    do_op(0, 0, 1, 0, 0, 32'h22, 32'h0BAD0BAD, 5'd0, 32'h0, 0, 0, 1, 0);
    do_op(0, 1, 0, 1, 1, 32'h20, 32'h0, 5'd6, 32'h55AA55AA, 1, 1, 0, 0);
    do_op(2, 1, 0, 1, 1, 32'h0B, 32'h0, 5'd6, 32'h0, 1, 1, 1, 0);
    do_op(0, 0, 1, 0, 0, 32'h400, 32'h0000F00D, 5'd0, 32'h0, 0, 0, 0, 0);
    do_op(0, 1, 0, 1, 1, 32'h000, 32'h0, 5'd8, 32'h0000F00D, 1, 1, 0, 0);

    // Test 6: plain ALU op passes straight through without stalling.
    do_op(0, 0, 0, 1, 0, 32'h1234, 32'h0, 5'd7, 32'h0, 1, 0, 0, 0);
    do_op(2, 0, 0, 1, 0, 32'h1234, 32'h0, 5'd7, 32'h0, 1, 0, 0, 0);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
